// File: rtl/fft_readout_unit.sv
`default_nettype none
// ============================================================================
// Module      : fft_readout_unit
// Description : Reader side of the FFT working-memory ping-pong. Streams the
//               half-spectrum bins 0..N/2-1 of the final result bank to a
//               valid/ready output. A credit-controlled FWFT FIFO with
//               registered outputs hides the RAM read latency.
// Options     : FFT_READOUT_MAG_EN - when defined, a registered stage replaces
//               {re,im} by max(|re|,|im|) + (min(|re|,|im|) >> 1).
// Revision    : 1.0 - initial release
// ============================================================================
module fft_readout_unit #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int RAM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                bank_i,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic                ram_rd_o,
  output logic                ram_sel_o,
  input  logic [DATA_W-1:0]   ram_re_i,
  input  logic [DATA_W-1:0]   ram_im_i,
  output logic                bin_valid_o,
  input  logic                bin_ready_i,
  output logic [ADDR_W-2:0]   bin_index_o,
  output logic [2*DATA_W-1:0] bin_data_o,
  output logic                bin_last_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int IDX_W   = ADDR_W - 1;
  localparam int ENTRY_W = 1 + IDX_W + 2*DATA_W;
  localparam int STORE_N = FIFO_DEPTH - 1;   // entries behind the output register
  localparam int PTR_W   = (STORE_N > 1) ? $clog2(STORE_N) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W   = $clog2(FIFO_DEPTH + RAM_LAT + 2) + 1;
`ifdef FFT_READOUT_MAG_EN
  localparam int NL_STAGES = RAM_LAT;        // in-flight stages not landing this cycle
`else
  localparam int NL_STAGES = RAM_LAT - 1;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  generate
    if (FIFO_DEPTH < RAM_LAT + 2 || RAM_LAT < 1) begin : g_param_check
      $error("fft_readout_unit: need RAM_LAT >= 1 and FIFO_DEPTH >= RAM_LAT+2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    rd_q, rd_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic                    bank_q, bank_d;

  logic [RAM_LAT-1:0]      pipe_vld_q, pipe_vld_d;
  logic [RAM_LAT-1:0]      pipe_last_q, pipe_last_d;
  logic [IDX_W-1:0]        pipe_idx_q [RAM_LAT];
  logic [IDX_W-1:0]        pipe_idx_d [RAM_LAT];

  logic                    land_vld;
  logic [ENTRY_W-1:0]      land_entry;

  logic                    out_vld_q, out_vld_d;
  logic [ENTRY_W-1:0]      out_entry_q, out_entry_d;
  logic [ENTRY_W-1:0]      mem_q [STORE_N];
  logic [ENTRY_W-1:0]      mem_d [STORE_N];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        st_cnt_q, st_cnt_d;
  logic [CNT_W-1:0]        fifo_cnt_d;
  logic                    pop, st_push, st_pop;

  logic [CRD_W-1:0]        inflight_nl;
  logic                    credit_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(STORE_N - 1)) ? '0 : p + 1'b1;
  endfunction

  // Strobe, bin index and last flag shift alongside each outstanding RAM read.
  always_comb begin
    pipe_vld_d  = '0;
    pipe_last_d = '0;
    for (int i = 0; i < RAM_LAT; i++) pipe_idx_d[i] = '0;
    for (int i = RAM_LAT - 1; i > 0; i--) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
      pipe_idx_d[i]  = pipe_idx_q[i-1];
    end
    pipe_vld_d[0]  = rd_q;
    pipe_idx_d[0]  = addr_q[IDX_W-1:0];
    pipe_last_d[0] = rd_q && (addr_q[IDX_W-1:0] == LAST_IDX);
  end

`ifdef FFT_READOUT_MAG_EN
  logic                   mag_vld_q, mag_vld_d, mag_last_q, mag_last_d;
  logic [IDX_W-1:0]       mag_idx_q, mag_idx_d;
  logic [DATA_W:0]        mag_val_q, mag_val_d;
  logic signed [DATA_W:0] re_s, im_s;
  logic [DATA_W:0]        re_abs, im_abs, mag_max, mag_min;

  // Approximate magnitude of the word returning from RAM; DATA_W+1 bits never overflow.
  always_comb begin
    re_s   = {ram_re_i[DATA_W-1], ram_re_i};
    im_s   = {ram_im_i[DATA_W-1], ram_im_i};
    re_abs = re_s[DATA_W] ? $unsigned(-re_s) : $unsigned(re_s);
    im_abs = im_s[DATA_W] ? $unsigned(-im_s) : $unsigned(im_s);
    if (re_abs >= im_abs) begin
      mag_max = re_abs;
      mag_min = im_abs;
    end else begin
      mag_max = im_abs;
      mag_min = re_abs;
    end
    mag_val_d  = mag_max + (mag_min >> 1);
    mag_vld_d  = pipe_vld_q[RAM_LAT-1];
    mag_last_d = pipe_last_q[RAM_LAT-1];
    mag_idx_d  = pipe_idx_q[RAM_LAT-1];
  end

  // Magnitude stage register; cleared by reset so returning stale data is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_vld_q  <= 1'b0;
      mag_last_q <= 1'b0;
      mag_idx_q  <= '0;
      mag_val_q  <= '0;
    end else begin
      mag_vld_q  <= mag_vld_d;
      mag_last_q <= mag_last_d;
      mag_idx_q  <= mag_idx_d;
      mag_val_q  <= mag_val_d;
    end
  end

  assign land_vld   = mag_vld_q;
  assign land_entry = {mag_last_q, mag_idx_q, {(DATA_W-1){1'b0}}, mag_val_q};
`else
  assign land_vld   = pipe_vld_q[RAM_LAT-1];
  assign land_entry = {pipe_last_q[RAM_LAT-1], pipe_idx_q[RAM_LAT-1], ram_re_i, ram_im_i};
`endif

  // FWFT FIFO: output register holds the head, a small ring holds the rest.
  always_comb begin
    out_vld_d   = out_vld_q;
    out_entry_d = out_entry_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    st_push     = 1'b0;
    st_pop      = 1'b0;
    pop         = out_vld_q & bin_ready_i;
    if (!out_vld_q || pop) begin
      if (st_cnt_q != '0) begin
        out_entry_d = mem_q[rd_ptr_q];
        out_vld_d   = 1'b1;
        st_pop      = 1'b1;
        st_push     = land_vld;
      end else begin
        out_vld_d = land_vld;
        if (land_vld) out_entry_d = land_entry;
      end
    end else begin
      st_push = land_vld;
    end
    if (st_push) begin
      mem_d[wr_ptr_q] = land_entry;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (st_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    st_cnt_d   = st_cnt_q + CNT_W'(st_push) - CNT_W'(st_pop);
    fifo_cnt_d = CNT_W'(out_vld_d) + st_cnt_d;
  end

  // Credit check against next-cycle occupancy, then read sequencing FSM.
  always_comb begin
    inflight_nl = CRD_W'(rd_q);
    for (int i = 0; i < NL_STAGES; i++) inflight_nl = inflight_nl + CRD_W'(pipe_vld_q[i]);
    credit_ok = (CRD_W'(fifo_cnt_d) + inflight_nl) < CRD_W'(FIFO_DEPTH);

    state_d = state_q;
    rd_d    = 1'b0;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_READ;
          bank_d  = bank_i;
          rd_d    = 1'b1;
          addr_d  = '0;
          cnt_d   = IDX_W'(1);
        end
      end
      S_READ: begin
        if (credit_ok) begin
          rd_d   = 1'b1;
          addr_d = {1'b0, cnt_q};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && out_entry_q[ENTRY_W-1]) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, read pipe and FIFO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      bank_q      <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      pipe_idx_q  <= '{default: '0};
      out_vld_q   <= 1'b0;
      out_entry_q <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      st_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      bank_q      <= bank_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      pipe_idx_q  <= pipe_idx_d;
      out_vld_q   <= out_vld_d;
      out_entry_q <= out_entry_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      st_cnt_q    <= st_cnt_d;
    end
  end

  assign ram_addr_o  = addr_q;
  assign ram_rd_o    = rd_q;
  assign ram_sel_o   = bank_q;
  assign bin_valid_o = out_vld_q;
  assign bin_last_o  = out_entry_q[ENTRY_W-1];
  assign bin_index_o = out_entry_q[2*DATA_W +: IDX_W];
  assign bin_data_o  = out_entry_q[2*DATA_W-1:0];
  assign busy_o      = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fft_readout_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_readout_unit
// Description : Self-checking bench for fft_readout_unit. Two-bank RAM model
//               with 2-cycle latency; each run's beats are compared against
//               the bank contents in natural bin order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_readout_unit;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 16;
  localparam int RAM_LAT    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int N2         = 1 << (ADDR_W - 1);
`ifdef FFT_READOUT_MAG_EN
  localparam int LAT = RAM_LAT + 3;
`else
  localparam int LAT = RAM_LAT + 2;
`endif

  logic                clk = 1'b0;
  logic                rst, start_i, bank_i, bin_ready_i;
  logic [ADDR_W-1:0]   ram_addr_o;
  logic                ram_rd_o, ram_sel_o;
  logic [DATA_W-1:0]   ram_re_i, ram_im_i;
  logic                bin_valid_o, bin_last_o, busy_o, done_o;
  logic [ADDR_W-2:0]   bin_index_o;
  logic [2*DATA_W-1:0] bin_data_o;

  logic [DATA_W-1:0]   mem_re [0:1][0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0]   mem_im [0:1][0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0]   a1;
  logic                s1;
  logic [2*DATA_W-1:0] cap [3];
  int                  n_cmp, n_fail;

  fft_readout_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .bank_i(bank_i),
    .ram_addr_o(ram_addr_o), .ram_rd_o(ram_rd_o), .ram_sel_o(ram_sel_o),
    .ram_re_i(ram_re_i), .ram_im_i(ram_im_i),
    .bin_valid_o(bin_valid_o), .bin_ready_i(bin_ready_i), .bin_index_o(bin_index_o),
    .bin_data_o(bin_data_o), .bin_last_o(bin_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // RAM with two-cycle read latency: address captured, then data registered.
  always @(posedge clk) begin
    a1       <= ram_addr_o;
    s1       <= ram_sel_o;
    ram_re_i <= mem_re[s1][a1];
    ram_im_i <= mem_im[s1][a1];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({ram_addr_o, ram_rd_o, ram_sel_o, bin_valid_o, bin_index_o,
                bin_data_o, bin_last_o, busy_o, done_o});
  endfunction

  // Expected beat payload for bin k of bank b.
  function automatic logic [2*DATA_W-1:0] exp_data(input bit b, input int k);
`ifdef FFT_READOUT_MAG_EN
    int re, im, mx, mn;
    re = int'($signed(mem_re[b][k]));
    im = int'($signed(mem_im[b][k]));
    if (re < 0) re = -re;
    if (im < 0) im = -im;
    mx = (re > im) ? re : im;
    mn = (re > im) ? im : re;
    return (2*DATA_W)'(mx + mn / 2);
`else
    return {mem_re[b][k], mem_im[b][k]};
`endif
  endfunction

  task automatic randomize_banks();
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem_re[0][i] = DATA_W'($urandom);
      mem_im[0][i] = DATA_W'($urandom);
      mem_re[1][i] = DATA_W'($urandom);
      mem_im[1][i] = DATA_W'($urandom);
    end
  endtask

  // mode 0: ready high; 1: ready low cycles 10..29; 2: random ready.
  task automatic run(input string name, input bit bank, input int mode, input int rst_beat, input int dup_start);
    int k, issued, max_out, first_v, first_rd, last_rd, last_xfer, done_cnt, done_cyc, t;
    bit finished, prev_hold;
    logic [ADDR_W-2:0]   prev_idx;
    logic [2*DATA_W-1:0] prev_data;
    k = 0; issued = 0; max_out = 0; first_v = -1; first_rd = -1; last_rd = -1;
    last_xfer = -1; done_cnt = 0; done_cyc = -1; finished = 1'b0; prev_hold = 1'b0;
    prev_idx = '0; prev_data = '0;
    @(negedge clk);
    check({name, " idle busy"}, 64'(busy_o), 64'd0);
    for (t = 0; t < 3000 && !finished; t++) begin
      start_i = (t == 0) || (t == dup_start);
      bank_i  = (t == 0) ? bank : 1'($urandom);
      case (mode)
        1:       bin_ready_i = !(t >= 10 && t <= 29);
        2:       bin_ready_i = ($urandom_range(0, 3) != 0);
        default: bin_ready_i = 1'b1;
      endcase
      if (ram_rd_o) begin
        issued++;
        last_rd = t;
        if (first_rd < 0) first_rd = t;
        check({name, " ram_sel"}, 64'(ram_sel_o), 64'(bank));
        if (issued - k > max_out) max_out = issued - k;
      end
      if (prev_hold) begin
        check({name, " hold valid"}, 64'(bin_valid_o), 64'd1);
        check({name, " hold index"}, 64'(bin_index_o), 64'(prev_idx));
        check({name, " hold data"}, 64'(bin_data_o), 64'(prev_data));
      end
      if (bin_valid_o && first_v < 0) first_v = t;
      if (done_o) begin
        done_cnt++;
        done_cyc = t;
      end
      if (bin_valid_o && bin_ready_i) begin
        check({name, " index"}, 64'(bin_index_o), 64'(k));
        check({name, " data"}, 64'(bin_data_o), 64'(exp_data(bank, k)));
        check({name, " last"}, 64'(bin_last_o), 64'(k == N2 - 1));
        if (k < 3) cap[k] = bin_data_o;
        k++;
        if (k == N2) last_xfer = t;
      end
      prev_hold = bin_valid_o && !bin_ready_i;
      prev_idx  = bin_index_o;
      prev_data = bin_data_o;
      if (rst_beat > 0 && k == rst_beat + 1) begin
        #2 rst = 1'b1;
        #1 check({name, " async reset outputs"}, out_vec(), 64'd0);
        start_i = 1'b0;
        bin_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (done_cyc >= 0 && t >= done_cyc + 3) finished = 1'b1;
      @(negedge clk);
    end
    start_i = 1'b0;
    check({name, " completed in budget"}, 64'(finished), 64'd1);
    check({name, " beat count"}, 64'(k), 64'(N2));
    check({name, " reads issued"}, 64'(issued), 64'(N2));
    check({name, " first rd cycle"}, 64'(first_rd), 64'd1);
    check({name, " first valid cycle"}, 64'(first_v), 64'(LAT));
    check({name, " done pulses"}, 64'(done_cnt), 64'd1);
    check({name, " done after last"}, 64'(done_cyc), 64'(last_xfer + 1));
    check({name, " credit bound"}, 64'(max_out <= FIFO_DEPTH), 64'd1);
    check({name, " busy after done"}, 64'(busy_o), 64'd0);
`ifndef FFT_READOUT_MAG_EN
    if (mode == 0) check({name, " full throughput"}, 64'(last_xfer), 64'(first_v + N2 - 1));
`endif
    if (mode == 1) begin
      check({name, " rd stalled"}, 64'(last_rd > N2), 64'd1);
      check({name, " fifo filled"}, 64'(max_out), 64'(FIFO_DEPTH));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    start_i = 1'b0;
    bank_i = 1'b0;
    bin_ready_i = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem_re[0][i] = DATA_W'(i);
      mem_im[0][i] = DATA_W'(i);
      mem_re[1][i] = DATA_W'($urandom);
      mem_im[1][i] = DATA_W'($urandom);
    end
    repeat (3) @(posedge clk);
    #1 check("reset outputs", out_vec(), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run("T1 basic", 1'b0, 0, 0, -1);
    randomize_banks();
    run("T2 stall", 1'b0, 1, 0, -1);
    run("T3 bank1", 1'b1, 2, 0, -1);
    run("T4 reset", 1'b0, 0, 100, -1);
    run("T4 restart", 1'b1, 0, 0, -1);
    run("T5 dup start", 1'b0, 0, 0, 50);

    mem_re[0][0] = 16'd3;     mem_im[0][0] = 16'd4;
    mem_re[0][1] = 16'h8000;  mem_im[0][1] = 16'd0;
    mem_re[0][2] = 16'hFF9C;  mem_im[0][2] = 16'hFF9C;
    run("T6 corner", 1'b0, 2, 0, -1);
`ifdef FFT_READOUT_MAG_EN
    check("mag 3,4", 64'(cap[0]), 64'd5);
    check("mag -32768,0", 64'(cap[1]), 64'd32768);
    check("mag -100,-100", 64'(cap[2]), 64'd150);
`else
    check("pass 3,4", 64'(cap[0]), 64'h0003_0004);
    check("pass -32768,0", 64'(cap[1]), 64'h8000_0000);
    check("pass -100,-100", 64'(cap[2]), 64'hFF9C_FF9C);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
